pmod_cls_line_sequencer: RTL and testbench

//  Parametrised successor to the two-line PMOD CLS command layer. Accepts clear and write-line commands for a display of

---
 rtl/pmod_cls_seq_pkg.sv | 45 ++++
 rtl/pmod_cls_seq_timer.sv | 29 ++
 rtl/pmod_cls_line_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_pmod_cls_line_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_cls_seq_pkg.sv
// Shared types, CLS escape-sequence constants and ce-tick delay helpers for pmod_cls_line_sequencer.
// Optional watchdog in the sequencer is enabled with PMOD_CLS_SEQ_TIMEOUT_EN.
package pmod_cls_seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_GO        = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_GAP       = 3'd6
    } t_cls_seq_state;

    localparam logic [7:0] C_ESC      = 8'h1B;
    localparam logic [7:0] C_LBRACKET = 8'h5B;
    localparam logic [7:0] C_SEMI     = 8'h3B;
    localparam logic [7:0] C_H        = 8'h48;
    localparam logic [7:0] C_J        = 8'h6A;
    localparam logic [7:0] C_ZERO     = 8'h30;

    localparam int unsigned CLEAR_LEN      = 3;
    localparam int unsigned WRITE_HDR_LEN  = 6;
    localparam int unsigned WATCHDOG_TICKS = 4096;
    localparam int unsigned FAST_SIM_DIV   = 1000;

    function automatic int unsigned ms_to_ticks(input int unsigned ms, input int unsigned fclk,
                                                input bit fast, input int unsigned min_ticks);
        longint unsigned t;
        t = 64'(ms) * 64'(fclk) / 64'd1000;
        if (fast) t = t / 64'(FAST_SIM_DIV);
        if (t < 64'(min_ticks)) t = 64'(min_ticks);
        return 32'(t);
    endfunction

    function automatic int unsigned us_to_ticks(input int unsigned us, input int unsigned fclk,
                                                input bit fast, input int unsigned min_ticks);
        longint unsigned t;
        t = 64'(us) * 64'(fclk) / 64'd1000000;
        if (fast) t = t / 64'(FAST_SIM_DIV);
        if (t < 64'(min_ticks)) t = 64'(min_ticks);
        return 32'(t);
    endfunction

endpackage

// File: rtl/pmod_cls_seq_timer.sv
// ce-gated loadable down-counter; o_done is high while the count is zero.
module pmod_cls_seq_timer
    import pmod_cls_seq_pkg::*;
#(
    parameter int unsigned parm_width = 16
) (
    input  logic                  i_clk_20mhz,
    input  logic                  i_rst_20mhz,
    input  logic                  i_ce,
    input  logic                  i_load,
    input  logic [parm_width-1:0] i_load_val,
    output logic                  o_done
);

    logic [parm_width-1:0] count;

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_ce && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign o_done = (count == '0);

endmodule

// File: rtl/pmod_cls_line_sequencer.sv
// Serialises clear / write-line commands into CLS escape sequences for pmod_generic_spi_solo.
// Define PMOD_CLS_SEQ_TIMEOUT_EN to add the SPI-wait watchdog and its o_timeout / o_timeout_count ports.
module pmod_cls_line_sequencer
    import pmod_cls_seq_pkg::*;
#(
    parameter int parm_fast_simulation = 0,
    parameter int FCLK_ce              = 2500000,
    parameter int parm_lines           = 2,
    parameter int parm_cols            = 16,
    parameter int parm_tx_len_bits     = 11,
    parameter int parm_wait_cyc_bits   = 2,
    parameter int parm_rx_len_bits     = 11,
    parameter int parm_boot_ms         = 20,
    parameter int parm_gap_us          = 200
) (
    input  logic                                                   i_clk_20mhz,
    input  logic                                                   i_rst_20mhz,
    input  logic                                                   i_ce_2_5mhz,
    input  logic                                                   i_cmd_valid,
    output logic                                                   o_cmd_ready,
    input  logic                                                   i_cmd_clear,
    input  logic [((parm_lines > 1) ? $clog2(parm_lines) : 1)-1:0] i_cmd_line,
    input  logic [8*parm_cols-1:0]                                 i_cmd_text,
    output logic                                                   o_go_stand,
    input  logic                                                   i_spi_idle,
    output logic [parm_tx_len_bits-1:0]                            o_tx_len,
    output logic [parm_wait_cyc_bits-1:0]                          o_wait_cyc,
    output logic [parm_rx_len_bits-1:0]                            o_rx_len,
    output logic [7:0]                                             o_tx_data,
    output logic                                                   o_tx_enqueue,
    input  logic                                                   i_tx_ready,
`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
    output logic                                                   o_timeout,
    output logic [7:0]                                             o_timeout_count,
`endif
    output logic                                                   o_busy
);

    localparam int          LW         = (parm_lines > 1) ? $clog2(parm_lines) : 1;
    localparam bit          FAST       = (parm_fast_simulation != 0);
    localparam int unsigned BOOT_TICKS = ms_to_ticks(parm_boot_ms, FCLK_ce, FAST, 2);
    localparam int unsigned GAP_TICKS  = us_to_ticks(parm_gap_us, FCLK_ce, FAST, 1);
    localparam int unsigned TMAX_A     = (BOOT_TICKS > GAP_TICKS) ? BOOT_TICKS : GAP_TICKS;
    localparam int unsigned TMAX       = (TMAX_A > WATCHDOG_TICKS) ? TMAX_A : WATCHDOG_TICKS;
    localparam int          TW         = $clog2(TMAX + 1);
    localparam int unsigned WR_LEN     = WRITE_HDR_LEN + parm_cols;

    t_cls_seq_state         state, state_nx;
    logic                   boot_armed;
    logic                   clear_q;
    logic [LW-1:0]          line_q, line_cl;
    logic [8*parm_cols-1:0] text_q;
    logic [5:0]             idx, last_idx;
    logic [7:0]             cur_byte;
    logic                   tmr_load, tmr_done;
    logic [TW-1:0]          tmr_val;
    logic                   accept, enq, go;
`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
    logic                   wd_expire;
`endif

    pmod_cls_seq_timer #(.parm_width(TW)) u_timer (
        .i_clk_20mhz (i_clk_20mhz),
        .i_rst_20mhz (i_rst_20mhz),
        .i_ce        (i_ce_2_5mhz),
        .i_load      (tmr_load & i_ce_2_5mhz),
        .i_load_val  (tmr_val),
        .o_done      (tmr_done)
    );

    assign line_cl  = (int'(i_cmd_line) >= parm_lines) ? LW'(parm_lines - 1) : i_cmd_line;
    assign last_idx = clear_q ? 6'(CLEAR_LEN - 1) : 6'(WR_LEN - 1);

    always_comb begin
        case (idx)
            6'd0:    cur_byte = C_ESC;
            6'd1:    cur_byte = C_LBRACKET;
            6'd2:    cur_byte = clear_q ? C_J : (C_ZERO + 8'(line_q));
            6'd3:    cur_byte = C_SEMI;
            6'd4:    cur_byte = C_ZERO;
            6'd5:    cur_byte = C_H;
            default: cur_byte = text_q[8*parm_cols-1 -: 8];
        endcase
    end

    // Boot spends its first ce arming the timer, hence the load of BOOT_TICKS-2.
    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        accept   = 1'b0;
        enq      = 1'b0;
        go       = 1'b0;
`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
        wd_expire = 1'b0;
`endif
        case (state)
            ST_BOOT: begin
                if (!boot_armed) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(BOOT_TICKS - 2);
                end else if (tmr_done) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (i_tx_ready) begin
                    enq = 1'b1;
                    if (idx == last_idx) state_nx = ST_GO;
                end
            end
            ST_GO: begin
                if (i_spi_idle) begin
                    go       = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(WATCHDOG_TICKS - 1);
                    state_nx = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
                if (tmr_done) begin
                    wd_expire = 1'b1;
                    state_nx  = ST_GAP;
                end else
`endif
                if (!i_spi_idle) state_nx = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
                if (tmr_done) begin
                    wd_expire = 1'b1;
                    state_nx  = ST_GAP;
                end else
`endif
                if (i_spi_idle) state_nx = ST_GAP;
            end
            ST_GAP: begin
                if (tmr_done) state_nx = ST_IDLE;
            end
            default: state_nx = ST_BOOT;
        endcase
        if (state_nx == ST_GAP && state != ST_GAP) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(GAP_TICKS - 1);
        end
    end

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state        <= ST_BOOT;
            boot_armed   <= 1'b0;
            clear_q      <= 1'b0;
            line_q       <= '0;
            text_q       <= '0;
            idx          <= '0;
            o_go_stand   <= 1'b0;
            o_tx_len     <= '0;
            o_tx_data    <= '0;
            o_tx_enqueue <= 1'b0;
`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
            o_timeout       <= 1'b0;
            o_timeout_count <= '0;
`endif
        end else if (i_ce_2_5mhz) begin
            state        <= state_nx;
            o_go_stand   <= go;
            o_tx_enqueue <= enq;
            if (state == ST_BOOT) boot_armed <= 1'b1;
            if (accept) begin
                clear_q <= i_cmd_clear;
                line_q  <= line_cl;
                text_q  <= i_cmd_text;
                idx     <= '0;
            end
            // Text bytes are taken from the top of a shifting copy of the latched line.
            if (enq) begin
                o_tx_data <= cur_byte;
                idx       <= idx + 1'b1;
                if (idx >= 6'(WRITE_HDR_LEN)) text_q <= text_q << 8;
            end
            if (go) o_tx_len <= parm_tx_len_bits'(idx);
`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
            o_timeout <= wd_expire;
            if (wd_expire && o_timeout_count != 8'hFF) o_timeout_count <= o_timeout_count + 1'b1;
`endif
        end
    end

    assign o_cmd_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);
    assign o_wait_cyc  = '0;
    assign o_rx_len    = '0;

endmodule

// File: tb/tb_pmod_cls_line_sequencer.sv
// Directed + randomized bench for pmod_cls_line_sequencer against a byte-sequence reference model.
// Watchdog scenario compiles in when PMOD_CLS_SEQ_TIMEOUT_EN is defined.
module tb_pmod_cls_line_sequencer;

    localparam int FCLK    = 2500000;
    localparam int LINES   = 3;
    localparam int COLS    = 16;
    localparam int BOOT    = 20 * (FCLK / 1000) / 1000;
    localparam int GAP_RAW = 200 * (FCLK / 1000) / 1000 / 1000;
    localparam int GAP     = (GAP_RAW < 1) ? 1 : GAP_RAW;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce = 1'b0;
    logic         cmd_valid, cmd_clear;
    logic [1:0]   cmd_line;
    logic [127:0] cmd_text;
    logic         spi_idle = 1'b1;
    logic         tx_ready;
    logic         cmd_ready, go_stand, tx_enqueue, busy;
    logic [10:0]  tx_len, rx_len;
    logic [1:0]   wait_cyc;
    logic [7:0]   tx_data;
`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
    logic         timeout;
    logic [7:0]   timeout_count;
`endif

    pmod_cls_line_sequencer #(
        .parm_fast_simulation (1),
        .FCLK_ce              (FCLK),
        .parm_lines           (LINES),
        .parm_cols            (COLS)
    ) dut (
        .i_clk_20mhz  (clk),
        .i_rst_20mhz  (rst),
        .i_ce_2_5mhz  (ce),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_clear  (cmd_clear),
        .i_cmd_line   (cmd_line),
        .i_cmd_text   (cmd_text),
        .o_go_stand   (go_stand),
        .i_spi_idle   (spi_idle),
        .o_tx_len     (tx_len),
        .o_wait_cyc   (wait_cyc),
        .o_rx_len     (rx_len),
        .o_tx_data    (tx_data),
        .o_tx_enqueue (tx_enqueue),
        .i_tx_ready   (tx_ready),
`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
        .o_timeout       (timeout),
        .o_timeout_count (timeout_count),
`endif
        .o_busy       (busy)
    );

    always #25 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int n = 0, ce_ph = 0;
    int go_cnt = 0, go_n = 0, accepts = 0, rises = 0, rise_n = 0, idle_n = 0;
    int ready_at = 0, stall_viol = 0, busy_left = 0, to_n = 0, to_cnt = 0;
    logic [10:0] go_len = '0;
    bit ready_before = 0, spi_auto = 1;
    logic [7:0] got[$];

    // Sampler / SPI responder: runs on the falling edge right after each ce rising edge.
    always @(negedge clk) begin
        if (rst) begin
            n = 0; ready_before = 0; ready_at = 0; busy_left = 0; spi_idle = 1'b1;
        end else if (ce) begin
            n++;
            if (tx_enqueue) begin
                got.push_back(tx_data);
                if (!tx_ready) stall_viol++;
            end
            if (go_stand) begin
                go_cnt++; go_len = tx_len; go_n = n;
                if (spi_auto) begin spi_idle = 1'b0; busy_left = $urandom_range(2, 5); end
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin spi_idle = 1'b1; idle_n = n; end
            end
            if (ready_before && cmd_valid) accepts++;
            if (!ready_before && cmd_ready) begin
                rises++; rise_n = n;
                if (ready_at == 0) ready_at = n;
            end
`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
            if (timeout) begin to_n = n; to_cnt++; end
`endif
            ready_before = cmd_ready;
        end
        ce_ph = (ce_ph + 1) % 8;
        ce = (ce_ph == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ce(input int k);
        int target;
        target = n + k;
        while (n < target) tick();
    endtask

    task automatic wait_rise(input int r0, input int limit, input string tag);
        int t;
        t = 0;
        while (rises == r0 && t < limit) begin tick(); t++; end
        chk(tag, 32'(rises != r0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_go"}, 32'(go_stand), 32'd0);
        chk({tag, "_enq"}, 32'(tx_enqueue), 32'd0);
        chk({tag, "_len"}, 32'(tx_len), 32'd0);
        chk({tag, "_data"}, 32'(tx_data), 32'd0);
    endtask

    // Reference model: the escape sequence the display should receive for one command.
    function automatic void build_expected(input bit clr, input logic [1:0] line,
                                           input logic [127:0] txt, output logic [7:0] exp[$]);
        int row;
        exp.delete();
        exp.push_back(8'h1B);
        exp.push_back(8'h5B);
        if (clr) begin
            exp.push_back(8'h6A);
        end else begin
            row = (int'(line) >= LINES) ? LINES - 1 : int'(line);
            exp.push_back(8'(8'h30 + row));
            exp.push_back(8'h3B);
            exp.push_back(8'h30);
            exp.push_back(8'h48);
            for (int c = 0; c < COLS; c++) exp.push_back(txt[127 - 8*c -: 8]);
        end
    endfunction

    task automatic issue(input bit clr, input logic [1:0] line, input logic [127:0] txt, input string tag);
        int a0, t;
        a0 = accepts;
        cmd_clear = clr; cmd_line = line; cmd_text = txt; cmd_valid = 1'b1;
        t = 0;
        while (accepts == a0 && t < 200) begin tick(); t++; end
        cmd_valid = 1'b0;
        chk({tag, "_accept"}, 32'(accepts - a0), 32'd1);
    endtask

    task automatic run_cmd(input bit clr, input logic [1:0] line, input logic [127:0] txt,
                           input int stall_at, input bit poke, input string tag);
        logic [7:0] exp[$];
        int base, g0, a0, r0, mis;
        build_expected(clr, line, txt, exp);
        base = got.size(); g0 = go_cnt; r0 = rises;
        issue(clr, line, txt, tag);
        a0 = accepts;
        if (poke) begin
            cmd_valid = 1'b1; cmd_clear = 1'b1;
            wait_ce(3);
            cmd_valid = 1'b0;
        end
        if (stall_at >= 0) begin
            wait_ce(stall_at);
            tx_ready = 1'b0;
            wait_ce(5);
            tx_ready = 1'b1;
        end
        wait_rise(r0, 4000, {tag, "_ready_back"});
        chk({tag, "_nbytes"}, 32'(got.size() - base), 32'(exp.size()));
        mis = 0;
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got.size()) chk({tag, "_byte"}, 32'(got[base + i]), 32'(exp[i]));
            else chk({tag, "_byte_missing"}, 32'hDEAD, 32'(exp[i]));
        end
        chk({tag, "_go_count"}, 32'(go_cnt - g0), 32'd1);
        chk({tag, "_tx_len"}, 32'(go_len), 32'(exp.size()));
        chk({tag, "_gap"}, 32'(rise_n - idle_n), 32'(1 + GAP));
        chk({tag, "_no_extra_accept"}, 32'(accepts - a0), 32'd0);
    endtask

    initial begin
        logic [127:0] txt;
        int g0, r0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_line = '0; cmd_text = '0; tx_ready = 1'b1;
        repeat (4) tick();
        check_reset_outputs("reset");
        chk("reset_wait_cyc", 32'(wait_cyc), 32'd0);
        chk("reset_rx_len", 32'(rx_len), 32'd0);
        rst = 1'b0;

        // T1 boot hold-off
        wait_rise(0, BOOT * 8 + 200, "boot_ready_seen");
        chk("boot_ticks", 32'(ready_at), 32'(BOOT));

        // T2 clear, T3 write, T4 stall, T5 clamp + busy poke
        run_cmd(1'b1, 2'd0, '0, -1, 1'b0, "clear");
        txt = "HELLO WORLD     ";
        run_cmd(1'b0, 2'd1, txt, -1, 1'b0, "hello");
        run_cmd(1'b0, 2'd2, txt, 4, 1'b0, "stall");
        run_cmd(1'b0, 2'd3, txt, -1, 1'b1, "clamp_poke");

        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < COLS; c++) txt[8*c +: 8] = 8'($urandom_range(32, 126));
            run_cmd(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), txt,
                    $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : -1, 1'b0, "rand");
        end
        chk("stall_violations", 32'(stall_viol), 32'd0);

        // Reset mid-load: no go pulse, full hold-off again
        g0 = go_cnt;
        issue(1'b0, 2'd0, txt, "midrst");
        wait_ce(3);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        wait_rise(rises, BOOT * 8 + 200, "midrst_ready_seen");
        chk("midrst_boot_ticks", 32'(ready_at), 32'(BOOT));
        chk("midrst_no_go", 32'(go_cnt - g0), 32'd0);

`ifdef PMOD_CLS_SEQ_TIMEOUT_EN
        spi_auto = 0;
        r0 = rises;
        issue(1'b1, 2'd0, '0, "wdog");
        begin
            int t;
            t = 0;
            while (to_cnt == 0 && t < 4200 * 8) begin tick(); t++; end
        end
        chk("wdog_fired", 32'(to_cnt), 32'd1);
        chk("wdog_ticks", 32'(to_n - go_n), 32'd4096);
        chk("wdog_count", 32'(timeout_count), 32'd1);
        wait_rise(r0, 400, "wdog_ready_back");
        chk("wdog_gap", 32'(rise_n - to_n), 32'(GAP));
        spi_auto = 1;
`else
        r0 = rises;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
